// File: rtl/vga_text_ctrl_pkg.sv
// Shared constants and types for the 80x30 text-mode VGA controller.
package vga_text_ctrl_pkg;

    // 640x480@60 Hz horizontal timing, in pixel clocks
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_TOTAL      = 10'd800;

    // Vertical timing, in lines
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam logic [9:0] V_TOTAL      = 10'd525;

    // Text geometry
    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 30;
    localparam int BUF_ROWS  = 32;
    localparam int BUF_COLS  = 128;
    localparam int GLYPH_W   = 8;
    localparam int GLYPH_H   = 16;

    // Cursor is drawn as an underline on the last two glyph rows
    localparam logic [3:0] CURSOR_FIRST_ROW = 4'd14;

    // Raw (undelayed) sync/blanking flags from the timing generator
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } sync_t;

    // Character buffer address layout {row[4:0], col[6:0]}
    function automatic logic [11:0] buf_addr(input logic [4:0] row, input logic [6:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480 raster counters, raw sync/active flags and frame-start pulse.
module vga_timing
    import vga_text_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output sync_t      sync_raw,
    output logic       frame_start
);

    // Pixel/line counters: h wraps at end of line and advances v
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_TOTAL - 10'd1) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Sync pulses are active low; active marks the visible 640x480 window
    always_comb begin
        sync_raw.hs     = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
        sync_raw.vs     = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
        sync_raw.active = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
    end

    // The counters sit at the origin throughout reset, so mask the pulse there
    assign frame_start = (h_cnt == '0) && (v_cnt == '0) && !clr;

endmodule

// File: rtl/vga_text_ctrl.sv
// 80x30 text-mode VGA controller: character/font fetch pipeline, scroll
// latch, blinking underline cursor and registered pin outputs.
module vga_text_ctrl
    import vga_text_ctrl_pkg::*;
#(
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] vga_line,
    input  logic        cursor_en,
    input  logic [11:0] cursor_pos,
    output logic [11:0] char_addr,
    input  logic [7:0]  char_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        frame_start
);

    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [9:0]         h_cnt;
    logic [9:0]         v_cnt;
    sync_t              sync_raw;
    logic [4:0]         scroll;
    logic [4:0]         scroll_eff;
    logic [4:0]         buf_row;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase;

    logic [3:0]  glyph_row_p0;
    logic [2:0]  hpix_p0;
    logic        vld_p0, hs_p0, vs_p0;
    logic [2:0]  hpix_p1;
    logic        cur_hit_p1;
    logic        vld_p1, hs_p1, vs_p1;
    logic        pixel_p2;
    logic [11:0] rgb;

    logic unused_bits;
    assign unused_bits = ^{vga_line[31:5], v_cnt[9]};

    function automatic logic [11:0] shade(input logic active, input logic pixel);
        if (!active)
            return 12'h000;
        return pixel ? FG_COLOR : BG_COLOR;
    endfunction

    vga_timing u_timing (
        .clk         (clk),
        .clr         (clr),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .sync_raw    (sync_raw),
        .frame_start (frame_start)
    );

    // The origin cycle already uses the incoming scroll so a whole frame
    // is rendered with one consistent offset.
    assign scroll_eff = frame_start ? vga_line[4:0] : scroll;
    assign buf_row    = v_cnt[8:4] + scroll_eff;

    // Scroll offset is captured once per frame
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            scroll <= '0;
        else if (frame_start)
            scroll <= vga_line[4:0];
    end

    // Blink timer: phase flips every BLINK_FRAMES frames, independent of cursor_en
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // ---- stage 0: counters -> character buffer address ----
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            char_addr    <= '0;
            glyph_row_p0 <= '0;
            hpix_p0      <= '0;
            vld_p0       <= 1'b0;
            hs_p0        <= 1'b1;
            vs_p0        <= 1'b1;
        end else begin
            char_addr    <= buf_addr(buf_row, h_cnt[9:3]);
            glyph_row_p0 <= v_cnt[3:0];
            hpix_p0      <= h_cnt[2:0];
            vld_p0       <= sync_raw.active;
            hs_p0        <= sync_raw.hs;
            vs_p0        <= sync_raw.vs;
        end
    end

    // ---- stage 1: character code -> font address, cursor hit ----
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            font_addr  <= '0;
            hpix_p1    <= '0;
            cur_hit_p1 <= 1'b0;
            vld_p1     <= 1'b0;
            hs_p1      <= 1'b1;
            vs_p1      <= 1'b1;
        end else begin
            font_addr  <= {char_data, glyph_row_p0};
            hpix_p1    <= hpix_p0;
            cur_hit_p1 <= cursor_en && phase && (char_addr == cursor_pos)
                          && (glyph_row_p0 >= CURSOR_FIRST_ROW);
            vld_p1     <= vld_p0;
            hs_p1      <= hs_p0;
            vs_p1      <= vs_p0;
        end
    end

    // ---- stage 2: glyph bit select (bit 7 is the leftmost pixel) ----
    assign pixel_p2 = font_data[~hpix_p1] ^ cur_hit_p1;
    assign rgb      = shade(vld_p1, pixel_p2);

    // ---- output register: all pins change on the same edge ----
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            {VGA_R, VGA_G, VGA_B} <= 12'h000;
            VGA_HS                <= 1'b1;
            VGA_VS                <= 1'b1;
        end else begin
            {VGA_R, VGA_G, VGA_B} <= rgb;
            VGA_HS                <= hs_p1;
            VGA_VS                <= vs_p1;
        end
    end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Randomised bench for vga_text_ctrl with a pixel-level raster reference model.
module tb_vga_text_ctrl;

    localparam int          BLINK     = 1;
    localparam logic [11:0] FG        = 12'hA5C;
    localparam logic [11:0] BG        = 12'h123;
    localparam int          LINE_CYC  = 800;
    localparam int          FRAME_CYC = 420000;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] vga_line = '0;
    logic        cursor_en = 1'b0;
    logic [11:0] cursor_pos = '0;
    logic [11:0] char_addr;
    logic [7:0]  char_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [3:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS;
    logic        frame_start;

    logic [7:0]  cbuf [0:4095];
    logic [7:0]  font [0:4095];

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [4:0]  m_scroll;
    logic        m_cursor_en;
    logic [11:0] m_cursor_pos;

    // External character buffer and font ROM
    assign char_data = cbuf[char_addr];
    assign font_data = font[font_addr];

    always #20 clk = ~clk;

    vga_text_ctrl #(
        .FG_COLOR     (FG),
        .BG_COLOR     (BG),
        .BLINK_FRAMES (BLINK)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .vga_line    (vga_line),
        .cursor_en   (cursor_en),
        .cursor_pos  (cursor_pos),
        .char_addr   (char_addr),
        .char_data   (char_data),
        .font_addr   (font_addr),
        .font_data   (font_data),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .frame_start (frame_start)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Buffer address shown at raster position (h, v)
    function automatic logic [11:0] addr_of(input int h, input int v);
        logic [4:0] r;
        logic [6:0] c;
        r = 5'(((v / 16) + int'(m_scroll)) % 32);
        c = 7'(h / 8);
        return {r, c};
    endfunction

    function automatic logic cursor_phase(input int p);
        int frame;
        frame = p / FRAME_CYC;
        return (((frame + 1) / BLINK) % 2) == 1;
    endfunction

    // {HS, VS, RGB} expected at the pins n cycles after reset release
    function automatic logic [13:0] exp_pins(input int n);
        int         p, h, v;
        logic       hs, vs, bit_on, hit;
        logic [7:0] code, row;
        logic [11:0] a, rgb;
        if (n < 3)
            return {2'b11, 12'h000};
        p  = n - 3;
        h  = p % LINE_CYC;
        v  = (p / LINE_CYC) % 525;
        hs = !(h >= 656 && h < 752);
        vs = !(v >= 490 && v < 492);
        rgb = 12'h000;
        if (h < 640 && v < 480) begin
            a      = addr_of(h, v);
            code   = cbuf[a];
            row    = font[{code, 4'(v % 16)}];
            bit_on = row[7 - (h % 8)];
            hit    = m_cursor_en && cursor_phase(p) && (a == m_cursor_pos) && ((v % 16) >= 14);
            rgb    = (bit_on ^ hit) ? FG : BG;
        end
        return {hs, vs, rgb};
    endfunction

    function automatic logic [11:0] exp_char_addr(input int n);
        int p;
        if (n < 1)
            return 12'h000;
        p = n - 1;
        return addr_of(p % LINE_CYC, (p / LINE_CYC) % 525);
    endfunction

    function automatic logic [11:0] exp_font_addr(input int n);
        int p, v;
        p = n - 2;
        v = (p / LINE_CYC) % 525;
        return {cbuf[addr_of(p % LINE_CYC, v)], 4'(v % 16)};
    endfunction

    task automatic check_reset_outputs();
        check_val("rst_pins", 32'({VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}), 32'({2'b11, 12'h000}));
        check_val("rst_char_addr", 32'(char_addr), 32'h0);
        check_val("rst_font_addr", 32'(font_addr), 32'h0);
        check_val("rst_frame_start", 32'(frame_start), 32'h0);
    endtask

    // kind: 1 = directed 'A' glyph, 2 = scroll wrap + cursor, 3 = all-ones font
    task automatic run_case(input int kind, input int ncyc, input logic [4:0] scr,
                            input logic en, input logic [11:0] cpos, input int rst_at_in);
        int n, cnt, rst_at, hs_low, first_low;
        logic [13:0] pins;
        rst_at       = rst_at_in;
        clr          = 1'b1;
        vga_line     = $urandom();
        vga_line[4:0] = scr;
        cursor_en    = en;
        cursor_pos   = cpos;
        m_cursor_en  = en;
        m_cursor_pos = cpos;
        m_scroll     = scr;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 clr = 1'b0;
        n = 0;
        cnt = 0;
        hs_low = 0;
        first_low = -1;
        while (cnt < ncyc) begin
            @(negedge clk);
            if (n == 0) begin
                m_scroll  = vga_line[4:0];
                first_low = -1;
            end
            pins = {VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B};
            check_val("pins", 32'(pins), 32'(exp_pins(n)));
            check_val("char_addr", 32'(char_addr), 32'(exp_char_addr(n)));
            if (n >= 2)
                check_val("font_addr", 32'(font_addr), 32'(exp_font_addr(n)));
            check_val("frame_start", 32'(frame_start), 32'((n % FRAME_CYC) == 0));

            if (!VGA_HS && first_low < 0)
                first_low = n;
            if (n == 700)
                check_val("first_hs_low", 32'(first_low), 32'd659);
            if (n == 3)
                hs_low = 0;
            if (n >= 3 && n < 803 && !VGA_HS)
                hs_low++;
            if (n == 803)
                check_val("hs_low_per_line", 32'(hs_low), 32'd96);

            if (kind == 1 && n >= 4 * LINE_CYC + 3 && n < 4 * LINE_CYC + 11)
                check_val("A_row4_px", 32'(pins[11:0]),
                          32'((n - (4 * LINE_CYC + 3) == 3 || n - (4 * LINE_CYC + 3) == 4) ? FG : BG));
            if (kind == 2 && n == 1)
                check_val("scroll_row0", 32'(char_addr[11:7]), 32'd31);
            if (kind == 2 && n == 16 * LINE_CYC + 1)
                check_val("scroll_row1_wrap", 32'(char_addr[11:7]), 32'd0);
            if (kind == 2 && n == 2000) begin
                vga_line = $urandom();
                vga_line[4:0] = 5'd7;
            end
            if (kind == 3 && n == 100 + 3)
                check_val("ones_visible", 32'(pins[11:0]), 32'(FG));
            if (kind == 3 && n == 700 + 3)
                check_val("ones_hblank", 32'(pins[11:0]), 32'h0);

            if (n == rst_at) begin
                #1 clr = 1'b1;
                #1 check_reset_outputs();
                repeat (3) @(posedge clk);
                #1 clr = 1'b0;
                n = 0;
                rst_at = -1;
            end else begin
                n++;
            end
            cnt++;
        end
    endtask

    initial begin
        int r, c;
        logic [4:0] s;

        // Buffer filled with 'A', row 4 of its glyph is 8'h18; mid-line reset at h=300, v=5
        for (int i = 0; i < 4096; i++) begin
            cbuf[i] = 8'h41;
            font[i] = 8'($urandom());
        end
        font[{8'h41, 4'd4}] = 8'h18;
        run_case(1, 6000, 5'($urandom_range(0, 31)), 1'b0, 12'h000, 5 * LINE_CYC + 300);

        // Random text, scroll 31 (row wrap), visible cursor within the first rows
        for (int i = 0; i < 4096; i++) begin
            cbuf[i] = 8'($urandom());
            font[i] = 8'($urandom());
        end
        r = $urandom_range(0, 2);
        c = $urandom_range(0, 79);
        run_case(2, 50 * LINE_CYC, 5'd31, 1'b1, {5'((r + 31) % 32), 7'(c)}, -1);

        // All-ones glyphs: blanking must still force black
        for (int i = 0; i < 4096; i++)
            font[i] = 8'hFF;
        run_case(3, 2000, 5'($urandom_range(0, 31)), 1'b0, 12'h000, -1);

        // Cursor disabled while pointing at an on-screen cell
        for (int i = 0; i < 4096; i++)
            font[i] = 8'($urandom());
        s = 5'($urandom_range(0, 31));
        run_case(4, 20 * LINE_CYC, s, 1'b0, {s, 7'($urandom_range(0, 79))}, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
